// File: rtl/thiele_mem_responder.sv
// Memory-side responder for the thiele_cpu bus: single-port word RAM with a
// registered read, streaming program loader that holds the CPU, write protection and counters.
module thiele_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int PROT_WORDS  = 128,
    parameter int DATA_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_en,
    input  logic                          mem_we,
    input  logic [31:0]                   mem_addr,
    input  logic [DATA_W-1:0]             mem_wdata,
    output logic [DATA_W-1:0]             mem_rdata,
    input  logic                          ld_start,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [DATA_W-1:0]             ld_data,
    input  logic                          ld_last,
    output logic                          cpu_hold,
    output logic [$clog2(DEPTH_WORDS):0]  ld_words,
    output logic                          err_oob,
    output logic                          err_wprot,
    output logic [31:0]                   err_addr,
    output logic [31:0]                   rd_count,
    output logic [31:0]                   wr_count
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] PROT_LIM = PROT_WORDS;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     ptr_q;
    logic [AW:0]       ld_words_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_oob_q, err_wprot_q;
    logic [31:0]       err_addr_q, rd_count_q, wr_count_q;
    logic [DATA_W-1:0] ram_q [DEPTH_WORDS];

    logic          ld_hs, start_load, cpu_rd, cpu_wr, in_rng, prot;
    logic          wr_commit, oob_hit, wprot_hit;
    logic [AW-1:0] idx_w;

    assign ld_hs      = (state_q == S_LOAD) && ld_valid;
    assign start_load = ld_start && (state_q != S_LOAD);
    assign cpu_rd     = (state_q == S_RUN) && mem_en && !mem_we;
    assign cpu_wr     = (state_q == S_RUN) && mem_en && mem_we;
    assign in_rng     = (mem_addr[31:AW+2] == '0);
    assign idx_w      = mem_addr[AW+1:2];
    assign prot       = in_rng && ({2'b00, mem_addr[31:2]} < PROT_LIM);
    assign wr_commit  = cpu_wr && in_rng && !prot;
    assign oob_hit    = (cpu_rd || cpu_wr) && !in_rng;
    assign wprot_hit  = cpu_wr && prot;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ld_start) state_d = S_LOAD;
            S_LOAD:  if (ld_hs && (ld_last || ptr_q == AW'(DEPTH_WORDS - 1))) state_d = S_RUN;
            S_RUN:   if (ld_start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            ld_words_q  <= '0;
            rdata_q     <= '0;
            err_oob_q   <= 1'b0;
            err_wprot_q <= 1'b0;
            err_addr_q  <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_load) begin
                ptr_q      <= '0;
                ld_words_q <= '0;
            end else if (ld_hs) begin
                ptr_q      <= ptr_q + 1'b1;
                ld_words_q <= ld_words_q + 1'b1;
            end
            if (cpu_rd) begin
                rdata_q    <= in_rng ? ram_q[idx_w] : '0;
                rd_count_q <= rd_count_q + 1'b1;
            end
            if (wr_commit) wr_count_q <= wr_count_q + 1'b1;
            if (oob_hit)   err_oob_q   <= 1'b1;
            if (wprot_hit) err_wprot_q <= 1'b1;
            // First error wins: later errors leave the captured address alone.
            if ((oob_hit || wprot_hit) && !err_oob_q && !err_wprot_q)
                err_addr_q <= mem_addr;
        end
    end

    // RAM is never cleared; loader and CPU never own it in the same state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld_hs)          ram_q[ptr_q] <= ld_data;
            else if (wr_commit) ram_q[idx_w] <= mem_wdata;
        end
    end

    assign mem_rdata = rdata_q;
    assign ld_ready  = (state_q == S_LOAD);
    assign cpu_hold  = (state_q != S_RUN);
    assign ld_words  = ld_words_q;
    assign err_oob   = err_oob_q;
    assign err_wprot = err_wprot_q;
    assign err_addr  = err_addr_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
endmodule

// File: tb/tb_thiele_mem_responder.sv
// Directed bench for thiele_mem_responder: load, reads, errors, full load, reset and reload.
module tb_thiele_mem_responder;
    logic        clk = 1'b0;
    logic        rst, mem_en, mem_we, ld_start, ld_valid, ld_last;
    logic [31:0] mem_addr, mem_wdata, ld_data;
    logic [31:0] mem_rdata, err_addr, rd_count, wr_count;
    logic        ld_ready, cpu_hold, err_oob, err_wprot;
    logic [8:0]  ld_words;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] prog [10];

    thiele_mem_responder #(.DEPTH_WORDS(256), .PROT_WORDS(128), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ld_start(ld_start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .cpu_hold(cpu_hold), .ld_words(ld_words), .err_oob(err_oob), .err_wprot(err_wprot),
        .err_addr(err_addr), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_rd(input logic [31:0] a);
        mem_en = 1; mem_we = 0; mem_addr = a;
        tick();
        mem_en = 0;
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        mem_en = 1; mem_we = 1; mem_addr = a; mem_wdata = d;
        tick();
        mem_en = 0; mem_we = 0;
    endtask

    task automatic ld_word(input logic [31:0] d, input logic last);
        ld_valid = 1; ld_data = d; ld_last = last;
        tick();
        ld_valid = 0; ld_last = 0;
    endtask

    initial begin
        prog = '{32'h0A000001, 32'h0A010101, 32'h0A020201, 32'h0A030301, 32'h0B030001,
                 32'h0B030101, 32'h0C000301, 32'h07040201, 32'h0D050401, 32'hFF000000};
        rst = 1; mem_en = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
        ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = 0;
        tick(); tick();
        rst = 0;
        chk("rst_hold", 32'(cpu_hold), 1);
        chk("rst_ready", 32'(ld_ready), 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_words", 32'(ld_words), 0);
        chk("rst_errs", {30'd0, err_oob, err_wprot}, 0);
        chk("rst_eaddr", err_addr, 0);
        chk("rst_cnts", rd_count | wr_count, 0);
        cpu_rd(32'h0);
        chk("idle_rd_cnt", rd_count, 0);

        // Program load with gaps before words 3 and 7
        ld_start = 1; tick(); ld_start = 0;
        chk("load_ready", 32'(ld_ready), 1);
        chk("load_words0", 32'(ld_words), 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 6) tick();
            ld_word(prog[i], i == 9);
            if (i == 8) chk("load_hold9", 32'(cpu_hold), 1);
        end
        chk("load_words", 32'(ld_words), 10);
        chk("load_run_hold", 32'(cpu_hold), 0);
        chk("load_run_ready", 32'(ld_ready), 0);
        for (int i = 0; i < 10; i++) begin
            cpu_rd(32'(4 * i));
            chk($sformatf("prog_rd%0d", i), mem_rdata, prog[i]);
        end
        chk("rd_count10", rd_count, 10);

        // Out-of-range read, then a good read
        cpu_rd(32'h400);
        chk("oob_rdata", mem_rdata, 0);
        chk("oob_flag", 32'(err_oob), 1);
        chk("oob_eaddr", err_addr, 32'h400);
        cpu_rd(32'h8);
        chk("after_oob_rd", mem_rdata, 32'h0A020201);
        chk("after_oob_eaddr", err_addr, 32'h400);

        // Protected write dropped, unprotected write committed
        cpu_wr(32'h8, 32'hDEADBEEF);
        chk("wprot_flag", 32'(err_wprot), 1);
        chk("wprot_wrcnt", wr_count, 0);
        chk("wprot_rdata_hold", mem_rdata, 32'h0A020201);
        chk("wprot_eaddr", err_addr, 32'h400);
        cpu_rd(32'h8);
        chk("wprot_rd", mem_rdata, 32'h0A020201);
        cpu_wr(32'h200, 32'h29);
        cpu_rd(32'h200);
        chk("raw_rd", mem_rdata, 32'h29);
        chk("raw_wrcnt", wr_count, 1);
        chk("rd_count14", rd_count, 14);

        // Reload from RUN with a read in the same cycle
        mem_en = 1; mem_we = 0; mem_addr = 32'h0; ld_start = 1;
        tick();
        mem_en = 0; ld_start = 0;
        chk("reload_rd", mem_rdata, 32'h0A000001);
        chk("reload_hold", 32'(cpu_hold), 1);
        chk("reload_ready", 32'(ld_ready), 1);
        chk("reload_rdcnt", rd_count, 15);
        cpu_rd(32'h4);
        chk("held_rd_hold", mem_rdata, 32'h0A000001);
        chk("held_rd_cnt", rd_count, 15);
        ld_word(32'h11, 0); ld_word(32'h22, 0); ld_word(32'h33, 1);
        chk("reload_words", 32'(ld_words), 3);
        chk("reload_run", 32'(cpu_hold), 0);
        cpu_rd(32'h0); chk("reload_w0", mem_rdata, 32'h11);
        cpu_rd(32'h4); chk("reload_w1", mem_rdata, 32'h22);
        cpu_rd(32'h8); chk("reload_w2", mem_rdata, 32'h33);
        cpu_rd(32'hC); chk("reload_w3", mem_rdata, 32'h0A030301);

        // Full-depth load without ld_last
        ld_start = 1; tick(); ld_start = 0;
        for (int i = 0; i < 256; i++) begin
            ld_word(32'h1000 + 32'(i), 0);
            if (i == 254) chk("full_hold255", 32'(cpu_hold), 1);
        end
        chk("full_words", 32'(ld_words), 256);
        chk("full_ready", 32'(ld_ready), 0);
        chk("full_run", 32'(cpu_hold), 0);
        ld_word(32'hBAD, 0);
        chk("full_extra_words", 32'(ld_words), 256);
        cpu_rd(32'h3FC); chk("full_last_rd", mem_rdata, 32'h10FF);
        cpu_rd(32'h0);   chk("full_first_rd", mem_rdata, 32'h1000);

        // Reset after 5 of 10 words
        ld_start = 1; tick(); ld_start = 0;
        for (int i = 0; i < 5; i++) ld_word(32'hA0 + 32'(i), 0);
        rst = 1; tick(); rst = 0;
        chk("mrst_ready", 32'(ld_ready), 0);
        chk("mrst_hold", 32'(cpu_hold), 1);
        chk("mrst_words", 32'(ld_words), 0);
        chk("mrst_errs", {30'd0, err_oob, err_wprot}, 0);
        cpu_rd(32'h4);
        chk("mrst_rdata", mem_rdata, 0);
        chk("mrst_rdcnt", rd_count, 0);
        ld_start = 1; tick(); ld_start = 0;
        ld_word(32'h77, 1);
        cpu_rd(32'h0);  chk("mrst_w0", mem_rdata, 32'h77);
        cpu_rd(32'h10); chk("mrst_w4_kept", mem_rdata, 32'hA4);
        cpu_rd(32'h14); chk("mrst_w5_old", mem_rdata, 32'h1005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/thiele_mem_responder.md
Name: thiele_mem_responder

Overview:
- Memory-side responder for the thiele_cpu mem_en/mem_we/mem_addr/mem_wdata/mem_rdata bus.
- Synthesizable replacement for the ad-hoc bench instruction fetch model: a single-port word RAM with a fixed 1-cycle registered read.
- Adds a streaming program loader that holds the CPU in reset while it loads, plus a write-protected program region, sticky error flags and access counters.

Parameters:
- DEPTH_WORDS, 256, RAM depth in 32-bit words; power of two.
- PROT_WORDS, 128, words [0, PROT_WORDS) are read-only to the CPU in RUN. 0 disables protection.
- DATA_W, 32, word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- mem_en  in  1  CPU access strobe.
- mem_we  in  1  CPU write enable; qualified by mem_en.
- mem_addr  in  32  CPU byte address; bits [1:0] ignored.
- mem_wdata  in  DATA_W  CPU write data.
- mem_rdata  out  DATA_W  registered read data.
- ld_start  in  1  pulse: begin a program load.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader word accepted when ld_valid && ld_ready.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  final loader word, qualified by ld_valid.
- cpu_hold  out  1  high keeps the CPU in reset; drives the CPU rst_n as its inverse.
- ld_words  out  $clog2(DEPTH_WORDS)+1  number of words accepted in the last or current load.
- err_oob  out  1  sticky: CPU access at or beyond DEPTH_WORDS*4.
- err_wprot  out  1  sticky: CPU write into the protected region.
- err_addr  out  32  mem_addr of the first error since reset.
- rd_count  out  32  CPU reads served; wraps.
- wr_count  out  32  CPU writes committed; wraps.

Behaviour:
- Reset values:
  - state = IDLE, cpu_hold = 1, ld_ready = 0, mem_rdata = 0, ld_words = 0.
  - err_oob, err_wprot and err_addr = 0; rd_count and wr_count = 0.
  - RAM contents are not cleared by reset.
- IDLE state:
  - cpu_hold = 1, ld_ready = 0.
  - ld_start moves to LOAD and clears the load pointer and ld_words.
- LOAD state:
  - ld_ready = 1 and cpu_hold = 1.
  - Each handshake writes RAM[ptr] = ld_data, then increments ptr and ld_words.
  - An accepted word with ld_last moves to RUN on the next edge.
  - Accepting word index DEPTH_WORDS-1 also moves to RUN, with or without ld_last.
  - ld_ready is 0 in all states other than LOAD. Words not loaded keep their prior contents.
  - ld_start is ignored while in LOAD.
- RUN state:
  - cpu_hold = 0; the CPU bus is served.
  - ld_start moves to LOAD: cpu_hold = 1 from the next cycle, and any CPU access in that same cycle is still served.
- CPU bus (served in RUN only):
  - In IDLE and LOAD, accesses are ignored: mem_rdata holds, counters hold, no errors are raised.
  - Word index = mem_addr[31:2]. In range iff mem_addr < DEPTH_WORDS*4.
- Reads (mem_en && !mem_we at edge N):
  - mem_rdata = RAM[idx] after edge N, held until the next read.
  - Out-of-range reads return 0 and set err_oob.
  - rd_count increments on every read, including out-of-range reads.
- Writes (mem_en && mem_we):
  - RAM[idx] = mem_wdata at the edge; mem_rdata unchanged. wr_count increments only on commit.
  - Out of range: write dropped, err_oob set.
  - idx < PROT_WORDS: write dropped, err_wprot set.
- Read-after-write to the same address on the next cycle returns the new data.
- err_addr captures mem_addr only when no error flag is yet set (first error wins). Flags are cleared only by rst.
- Counters wrap 0xFFFFFFFF -> 0.
- rst mid-load or mid-run:
  - Returns to IDLE with cpu_hold = 1 on the next edge.
  - The partial load is abandoned; words already written remain in RAM.

Test Plan:
- Load sequence:
  - Stimulus: rst, ld_start, 10 words {0A000001, 0A010101, 0A020201, 0A030301, 0B030001, 0B030101, 0C000301, 07040201, 0D050401, FF000000}, with ld_valid gaps on words 3 and 7 and ld_last on word 10.
  - Response: ld_words = 10; RUN one cycle after the last handshake; cpu_hold falls.
  - Follow-up: reads of 0x0, 0x4 .. 0x24 return the words in order, one cycle late; rd_count = 10.
- Out-of-range read 0x400:
  - Response: mem_rdata = 0, err_oob = 1, err_addr = 0x400.
  - A following read of 0x8 returns 0A020201, and err_addr stays 0x400.
- Protected and unprotected writes:
  - Write 0xDEADBEEF to 0x8: dropped, err_wprot = 1, wr_count = 0.
  - Write 0x29 to 0x200, then read 0x200 on the next cycle: returns 0x29, wr_count = 1.
- Full-depth load:
  - Stimulus: stream DEPTH_WORDS words with no ld_last.
  - Response: RUN after word 256, ld_words = 256, ld_ready = 0 afterwards.
  - A 257th ld_valid is not accepted.
- Reset mid-load:
  - Stimulus: assert rst after 5 of 10 words.
  - Response: IDLE next edge, ld_ready = 0, cpu_hold = 1, ld_words = 0.
  - Response: CPU reads issued while held leave mem_rdata = 0 and rd_count = 0.
- Reload from RUN:
  - Stimulus: ld_start asserted in the same cycle as a CPU read.
  - Response: that read is served; cpu_hold = 1 the next cycle.
  - Response: a subsequent 3-word load overwrites words 0..2 only.
